// File: rtl/vx_int_muldiv_unit.sv
// vx_int_muldiv_unit: pipelined SIMD multiplier plus lockstep radix-2 divider sharing one
// registered, round-robin arbitrated result port; a pass-through tag returns with each result.
module vx_int_muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int LANES       = 4,
  parameter int MUL_LATENCY = 3,
  parameter int TAGW        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [2:0]             op_in,
  input  logic [TAGW-1:0]        tag_in,
  input  logic [LANES*WIDTH-1:0] a_in,
  input  logic [LANES*WIDTH-1:0] b_in,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [TAGW-1:0]        tag_out,
  output logic [LANES*WIDTH-1:0] data_out
);
  localparam int N  = LANES*WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 r_state, w_state_n;
  logic [CW-1:0]          r_cnt;
  logic                   r_fixed, r_rem_mode, r_rr, r_valid;
  logic [TAGW-1:0]        r_dtag, r_tag;
  logic [N-1:0]           r_data, r_ma, r_mb, w_mul_res, w_div_res;
  logic                   r_msa, r_msb;
  logic [MUL_LATENCY:0]   r_mv, r_mhi;
  logic [TAGW-1:0]        r_mtag [MUL_LATENCY+1];
  logic [2*N-1:0]         r_mp [MUL_LATENCY];
  logic [2*N-1:0]         w_prod;
  logic w_stall, w_mul_req, w_div_req, w_mul_grant, w_div_grant;
  logic w_mul_en, w_div_ready, w_mul_acc, w_div_acc, w_dsgn;

  assign w_stall     = r_valid && !ready_out;
  assign w_mul_req   = r_mv[MUL_LATENCY];
  assign w_mul_grant = !w_stall && w_mul_req && (!w_div_req || !r_rr);
  assign w_div_grant = !w_stall && w_div_req && (!w_mul_req || r_rr);
  assign w_mul_en    = !(w_mul_req && !w_mul_grant);
  assign ready_in    = op_in[2] ? w_div_ready : w_mul_en;
  assign w_mul_acc   = valid_in && !op_in[2] && w_mul_en;
  assign w_div_acc   = valid_in && op_in[2] && w_div_ready;
  assign w_dsgn      = !op_in[0];
  assign valid_out   = r_valid;
  assign tag_out     = r_tag;
  assign data_out    = r_data;

  // stage 0 holds operands; stages 1..MUL_LATENCY hold the product
  always_ff @(posedge clk or posedge reset)
    if (reset) r_mv <= '0;
    else if (w_mul_en) r_mv <= {r_mv[MUL_LATENCY-1:0], w_mul_acc};

  always_ff @(posedge clk)
    if (w_mul_en) begin
      r_ma      <= a_in;
      r_mb      <= b_in;
      r_msa     <= op_in == 3'd1 || op_in == 3'd2;
      r_msb     <= op_in == 3'd1;
      r_mhi     <= {r_mhi[MUL_LATENCY-1:0], op_in != 3'd0};
      r_mtag[0] <= tag_in;
      r_mp[0]   <= w_prod;
      for (int i = 1; i <= MUL_LATENCY; i++) r_mtag[i] <= r_mtag[i-1];
      for (int i = 1; i < MUL_LATENCY; i++) r_mp[i] <= r_mp[i-1];
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= (r_state == CALC) ? r_cnt + 1'b1 : '0;
      r_fixed <= r_state == DONE;
    end

  always_comb
    w_state_n = (r_state == IDLE && w_div_acc) ? CALC :
                (r_state == CALC && r_cnt == CW'(WIDTH-1)) ? DONE :
                w_div_grant ? IDLE : r_state;

  // the first DONE cycle applies sign fix-ups in place; the request follows it
  always_comb begin
    w_div_ready = r_state == IDLE;
    w_div_req   = r_state == DONE && r_fixed;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_dtag     <= '0;
      r_rem_mode <= 1'b0;
    end else if (w_div_acc) begin
      r_dtag     <= tag_in;
      r_rem_mode <= op_in[1];
    end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [2*WIDTH-1:0] w_ax, w_bx;
    logic [WIDTH-1:0]   w_a, w_b, w_abs_a, w_abs_b, r_quo, r_rem, r_b, w_diff;
    logic [WIDTH:0]     w_sh;
    logic               w_sa, w_sb, w_ge, r_qneg, r_rneg, r_bz;
    assign w_ax = {{WIDTH{r_msa & r_ma[l*WIDTH+WIDTH-1]}}, r_ma[l*WIDTH +: WIDTH]};
    assign w_bx = {{WIDTH{r_msb & r_mb[l*WIDTH+WIDTH-1]}}, r_mb[l*WIDTH +: WIDTH]};
    assign w_prod[l*2*WIDTH +: 2*WIDTH] = w_ax * w_bx;
    assign w_mul_res[l*WIDTH +: WIDTH] = r_mhi[MUL_LATENCY] ?
      r_mp[MUL_LATENCY-1][l*2*WIDTH+WIDTH +: WIDTH] : r_mp[MUL_LATENCY-1][l*2*WIDTH +: WIDTH];
    assign w_a     = a_in[l*WIDTH +: WIDTH];
    assign w_b     = b_in[l*WIDTH +: WIDTH];
    assign w_sa    = w_dsgn & w_a[WIDTH-1];
    assign w_sb    = w_dsgn & w_b[WIDTH-1];
    assign w_abs_a = w_sa ? -w_a : w_a;
    assign w_abs_b = w_sb ? -w_b : w_b;
    assign w_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = w_sh >= {1'b0, r_b};
    assign w_diff  = w_sh[WIDTH-1:0] - r_b;
    assign w_div_res[l*WIDTH +: WIDTH] = r_rem_mode ? r_rem : r_quo;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        {r_quo, r_rem, r_b, r_qneg, r_rneg, r_bz} <= '0;
      end else if (w_div_acc) begin
        r_quo  <= w_abs_a;
        r_rem  <= '0;
        r_b    <= w_abs_b;
        r_qneg <= w_sa ^ w_sb;
        r_rneg <= w_sa;
        r_bz   <= w_b == '0;
      end else if (r_state == CALC) begin
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_rem <= w_ge ? w_diff : w_sh[WIDTH-1:0];
      end else if (r_state == DONE && !r_fixed) begin
        r_quo <= r_bz ? '1 : r_qneg ? -r_quo : r_quo;
        r_rem <= r_rneg ? -r_rem : r_rem;
      end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
      r_rr    <= 1'b0;
    end else if (!w_stall) begin
      r_valid <= w_mul_grant || w_div_grant;
      if (w_mul_grant) begin
        r_tag  <= r_mtag[MUL_LATENCY];
        r_data <= w_mul_res;
      end else if (w_div_grant) begin
        r_tag  <= r_dtag;
        r_data <= w_div_res;
      end
      if (w_mul_req && w_div_req) r_rr <= ~r_rr;
    end
endmodule

// File: tb/tb_vx_int_muldiv_unit.sv
// tb_vx_int_muldiv_unit: table vectors, model-checked random lanes, and hand-built
// collision, back-pressure and mid-operation reset sequences against a result scoreboard.
module tb_vx_int_muldiv_unit;
  localparam int W = 32, L = 4, T = 8;
  logic clk = 0, reset = 1, valid_in = 0, ready_in, ready_out = 1, valid_out;
  logic [2:0] op_in = 0;
  logic [T-1:0] tag_in = 0, tag_out;
  logic [L*W-1:0] a_in = 0, b_in = 0, data_out;

  always #5 clk = ~clk;

  vx_int_muldiv_unit #(.WIDTH(W), .LANES(L), .MUL_LATENCY(3), .TAGW(T)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in), .op_in(op_in),
    .tag_in(tag_in), .a_in(a_in), .b_in(b_in), .valid_out(valid_out), .ready_out(ready_out),
    .tag_out(tag_out), .data_out(data_out));

  typedef struct {logic [T-1:0] tag; logic [L*W-1:0] data;} exp_t;
  typedef struct {logic [2:0] op; logic [W-1:0] a, b, exp; int lat;} vec_t;
  exp_t sbq[$];
  exp_t m_e;
  vec_t vt[$];
  int n_chk = 0, n_pass = 0, lat;
  bit saw_stall = 0;
  logic [L*W-1:0] ra, rb, re, ra2, rb2, re2;
  logic [W-1:0] av, bv;

  task automatic check(input string name, input bit ok, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    longint p;
    logic [63:0] u;
    sa = a; sb = b;
    u = {32'b0, a} * {32'b0, b};
    if (op == 0) return u[31:0];
    if (op == 1) begin p = longint'(sa) * longint'(sb); return p[63:32]; end
    if (op == 2) begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
    if (op == 3) return u[63:32];
    if (b == 0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
    if (op == 4) return sa / sb;
    if (op == 5) return a / b;
    if (op == 6) return sa % sb;
    return a % b;
  endfunction

  task automatic push(input logic [T-1:0] tag, input logic [L*W-1:0] data);
    exp_t e;
    e.tag = tag; e.data = data;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [T-1:0] tag, input logic [L*W-1:0] a,
                       input logic [L*W-1:0] b, input logic [L*W-1:0] exp, input bit do_push);
    valid_in = 1; op_in = op; tag_in = tag; a_in = a; b_in = b;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (ready_in) begin
        @(posedge clk);
        if (do_push) push(tag, exp);
        #1 valid_in = 0;
        return;
      end
      saw_stall = 1;
    end
    check("issue_timeout", 0, 0, 1);
    valid_in = 0;
  endtask

  task automatic wait_valid(output int k_out);
    k_out = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (valid_out) begin k_out = k; return; end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(posedge clk);
    check("drain", sbq.size() == 0, L*W'(sbq.size()), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk)
    if (!reset && valid_out && ready_out) begin
      if (sbq.size() == 0) check("unexpected_result", 0, data_out, 0);
      else begin
        m_e = sbq.pop_front();
        check($sformatf("tag_%h", m_e.tag), tag_out == m_e.tag, L*W'(tag_out), L*W'(m_e.tag));
        check($sformatf("data_%h", m_e.tag), data_out == m_e.data, data_out, m_e.data);
      end
    end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4});
    vt.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4});
    vt.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4});
    vt.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4});
    vt.push_back('{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34});
    vt.push_back('{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34});
    vt.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 34});
    vt.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 34});
    vt.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 34});
    vt.push_back('{3'd7, 32'd5, 32'd0, 32'd5, 34});
    vt.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34});
    vt.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34});
    vt.push_back('{3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 34});
    vt.push_back('{3'd6, 32'd7, 32'hFFFFFFFE, 32'h00000001, 34});
    vt.push_back('{3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 34});
    vt.push_back('{3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 34});

    repeat (3) @(posedge clk); #1;
    check("rst_valid", valid_out == 0, L*W'(valid_out), 0);
    check("rst_tag", tag_out == 0, L*W'(tag_out), 0);
    check("rst_data", data_out == 0, data_out, 0);
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
    op_in = 4; #1;
    check("rdy_div_after_rst", ready_in == 1, L*W'(ready_in), 1);
    op_in = 0; #1;
    check("rdy_mul_after_rst", ready_in == 1, L*W'(ready_in), 1);

    foreach (vt[i]) begin
      issue(vt[i].op, T'(i), {L{vt[i].a}}, {L{vt[i].b}}, {L{vt[i].exp}}, 1);
      wait_valid(lat);
      check($sformatf("lat_vec%0d", i), lat == vt[i].lat, L*W'(lat), L*W'(vt[i].lat));
      @(posedge clk); #1;
    end

    for (int op = 0; op < 8; op++)
      for (int r = 0; r < 2; r++) begin
        for (int ln = 0; ln < L; ln++) begin
          av = $urandom; bv = $urandom;
          if (ln == 1) bv = $urandom_range(1, 20);
          if (ln == 2 && r == 1) bv = 0;
          ra[ln*W +: W] = av; rb[ln*W +: W] = bv;
          re[ln*W +: W] = ref_op(3'(op), av, bv);
        end
        issue(3'(op), T'(8'h80 + op*2 + r), ra, rb, re, 1);
        wait_valid(lat);
        check($sformatf("lat_rand_op%0d", op), lat == (op >= 4 ? 34 : 4), L*W'(lat), L*W'(op >= 4 ? 34 : 4));
        @(posedge clk); #1;
      end
    drain();

    // div DONE and last mul stage request on the same cycle, twice
    for (int c = 0; c < 2; c++) begin
      for (int ln = 0; ln < L; ln++) begin
        ra[ln*W +: W] = 100 + ln; rb[ln*W +: W] = 7;
        re[ln*W +: W] = ref_op(3'd5, 100 + ln, 7);
        ra2[ln*W +: W] = 3 + ln; rb2[ln*W +: W] = 5;
        re2[ln*W +: W] = ref_op(3'd0, 3 + ln, 5);
      end
      issue(3'd5, 8'h11, ra, rb, re, 0);
      repeat (29) @(posedge clk); #1;
      issue(3'd0, 8'h22, ra2, rb2, re2, 0);
      if (c == 0) begin push(8'h22, re2); push(8'h11, re); end
      else begin push(8'h11, re); push(8'h22, re2); end
      drain();
    end

    ready_out = 0; saw_stall = 0;
    fork
      begin repeat (10) @(posedge clk); #1 ready_out = 1; end
      for (int i = 0; i < 8; i++) begin
        for (int ln = 0; ln < L; ln++) begin
          av = $urandom; bv = $urandom;
          ra[ln*W +: W] = av; rb[ln*W +: W] = bv;
          re[ln*W +: W] = ref_op(3'(i % 4), av, bv);
        end
        issue(3'(i % 4), T'(8'h30 + i), ra, rb, re, 1);
      end
    join
    check("stream_ready_dropped", saw_stall == 1, L*W'(saw_stall), 1);
    drain();

    issue(3'd4, 8'h66, {L{32'd50}}, {L{32'd3}}, 0, 0);
    ready_out = 0;
    issue(3'd0, 8'h77, {L{32'd2}}, {L{32'd3}}, 0, 0);
    repeat (9) @(posedge clk); #1;
    check("pre_rst_valid", valid_out == 1, L*W'(valid_out), 1);
    check("pre_rst_tag", tag_out == 8'h77, L*W'(tag_out), L*W'(8'h77));
    reset = 1; #1;
    check("midrst_valid", valid_out == 0, L*W'(valid_out), 0);
    check("midrst_tag", tag_out == 0, L*W'(tag_out), 0);
    check("midrst_data", data_out == 0, data_out, 0);
    @(negedge clk) begin reset = 0; ready_out = 1; end
    @(posedge clk); #1;
    op_in = 4; #1;
    check("midrst_rdy", ready_in == 1, L*W'(ready_in), 1);
    issue(3'd4, 8'h99, {L{32'hFFFFFF9C}}, {L{32'd7}}, {L{32'hFFFFFFF2}}, 1);
    wait_valid(lat);
    check("lat_after_rst", lat == 34, L*W'(lat), 34);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
